sort_frame_loader: RTL and testbench
====================================

SORT_FRAME_LOADER -- requirements
Module: sort_frame_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of one key word.
REQ-002 The block SHALL have parameter N_INPUTS, default 8, giving the number of words per frame; the legal value is 8, which matches the sorting network's input count.
REQ-003 The block SHALL have parameter CW, default 4, giving the width of frame_words (clog2(N_INPUTS)+1).
REQ-004 clk  input  1  Single clock; all state updates on its rising edge.
REQ-005 rst  input  1  Reset, asynchronous and active-low.
REQ-006 s_valid  input  1  Upstream word valid.
REQ-007 s_data  input  DATA_WIDTH  Upstream key word.
REQ-008 s_last  input  1  Marks the final word of a short or full frame; qualified by s_valid.
REQ-009 s_ready  output  1  Loader can accept a word this cycle.
REQ-010 direction_in  input  1  Sort direction: 1 = ascending, 0 = descending; sampled with the first word of each frame.
REQ-011 flush  input  1  Closes a partially filled frame.
REQ-012 frame_data  output  N_INPUTS*DATA_WIDTH  Packed frame for the sorter's data_in.
REQ-013 frame_valid  output  1  frame_data, frame_dir and frame_words are valid and held.
REQ-014 frame_ready  input  1  Downstream (sorter issue logic) accepts the frame.
REQ-015 frame_dir  output  1  Direction latched for this frame; drives the sorter's direction.
REQ-016 frame_words  output  CW  Count of real (non-pad) words in the frame, range 1..N_INPUTS.

Function
REQ-017 The block SHALL implement two states: FILL (s_ready=1, frame_valid=0) and PRESENT (s_ready=0, frame_valid=1).
REQ-018 A word SHALL be accepted on a cycle with s_valid=1 and s_ready=1; with fill count k, it is written to lane k, bits [k*DATA_WIDTH +: DATA_WIDTH], so lane 0 holds the first word received.
REQ-019 On the first accepted word of a frame (k=0), the block SHALL latch direction_in into frame_dir; direction_in changes mid-frame SHALL be ignored.
REQ-020 In FILL, the block SHALL go to PRESENT on the edge where a word is accepted and any of the following holds: k=N_INPUTS-1, s_last=1, or flush=1.
REQ-021 In FILL with k>0 and flush=1 and no word accepted, the block SHALL go to PRESENT on that edge.
REQ-022 flush with k=0 and no word accepted SHALL be ignored.
REQ-023 On entry to PRESENT, every lane >= the final word count SHALL be loaded with the pad value: all-ones if frame_dir=1, all-zeros if frame_dir=0, so pad sorts to the tail.
REQ-024 On entry to PRESENT, frame_words SHALL equal the number of real words.
REQ-025 In PRESENT, frame_data, frame_dir and frame_words SHALL be held stable while frame_ready=0, and s_data SHALL be ignored.
REQ-026 In PRESENT, frame_valid=1 and frame_ready=1 on an edge SHALL return the block to FILL with k=0; lane contents need not be cleared.
REQ-027 s_ready SHALL be 0 in PRESENT, including the handoff cycle, so peak throughput is one full frame per N_INPUTS+1 cycles.
REQ-028 frame_valid SHALL be a registered output, asserted the cycle after the closing event (1-cycle latency from the closing word to frame_valid).
REQ-029 Simultaneous s_last and flush SHALL be treated as a single close event.
REQ-030 s_last arriving with the N_INPUTS-th word SHALL produce a full frame with no pad.
REQ-031 The fill counter SHALL never exceed N_INPUTS-1 in FILL; no overflow state exists.

Reset
REQ-032 While rst=0, asynchronously: state=FILL, k=0, frame_valid=0, s_ready=1 (after release), frame_dir=0, frame_words=0, frame_data=0.
REQ-033 Reset asserted mid-fill or mid-PRESENT SHALL discard the partial or held frame; no word accepted before reset SHALL appear in a later frame.

Verification
REQ-034 Full frame: dir=1, words 8,7,6,5,4,3,2,1 back-to-back with frame_ready=1 -> frame_valid one cycle after the 8th word; lane0=8 ... lane7=1; frame_words=8; s_ready low for exactly one cycle.
REQ-035 Short frame: dir=1, words 5,9,2 with s_last on 2 -> lanes0-2=5,9,2; lanes3-7=0xFFFFFFFF; frame_words=3. Repeat with dir=0 -> lanes3-7=0x00000000.
REQ-036 Backpressure: full frame, frame_ready=0 for 10 cycles -> frame_data stable, s_ready=0, s_valid words during the stall are not consumed; frame_ready=1 -> FILL next cycle.
REQ-037 Flush: 4 words accepted, then flush with s_valid=0 -> frame_words=4, pad in lanes4-7. flush with k=0 -> no frame_valid.
REQ-038 Direction latch: direction_in toggles after the first word -> frame_dir equals the value sampled at word 0.
REQ-039 Reset mid-fill: 5 words accepted, rst pulsed low asynchronously between edges -> outputs immediately at reset values; the next 8 words form a clean frame with lane0 = the first post-reset word.

Source files
------------

// File: rtl/sort_frame_loader_if.sv
// Word stream into the frame loader and packed frame out to the sorter.
// The loader connects through the slave modport.
interface sort_frame_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 8,
  parameter int CW         = 4
);
  logic                           s_valid;
  logic [DATA_WIDTH-1:0]          s_data;
  logic                           s_last;
  logic                           s_ready;
  logic                           direction_in;
  logic                           flush;
  logic [N_INPUTS*DATA_WIDTH-1:0] frame_data;
  logic                           frame_valid;
  logic                           frame_ready;
  logic                           frame_dir;
  logic [CW-1:0]                  frame_words;

  modport slave (
    input  s_valid, s_data, s_last, direction_in, flush, frame_ready,
    output s_ready, frame_data, frame_valid, frame_dir, frame_words
  );

  modport master (
    output s_valid, s_data, s_last, direction_in, flush, frame_ready,
    input  s_ready, frame_data, frame_valid, frame_dir, frame_words
  );
endinterface

// File: rtl/sort_frame_loader.sv
// Collects up to N_INPUTS key words into one packed frame for the sorting
// network, padding unused lanes so the pad always sorts to the tail.
//
// state   | meaning
// FILL    | accepting words into lane k, s_ready=1
// PRESENT | frame held for the sorter, frame_valid=1
module sort_frame_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 8,
  parameter int CW         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sort_frame_loader_if.slave   bus
);
  localparam int KW = $clog2(N_INPUTS);

  typedef enum logic {FILL, PRESENT} state_t;

  state_t                         state, state_nxt;
  logic [KW-1:0]                  k, k_nxt;
  logic [N_INPUTS*DATA_WIDTH-1:0] data_q, data_nxt;
  logic                           dir_q, dir_nxt;
  logic [CW-1:0]                  words_q, words_nxt;
  logic                           accept;
  logic                           close;
  logic [CW-1:0]                  count_final;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FILL;
      k       <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      data_q  <= data_nxt;
      dir_q   <= dir_nxt;
      words_q <= words_nxt;
    end
  end

  // A flush with no word in hand only closes a frame that already holds data.
  always_comb begin
    accept = (state == FILL) && bus.s_valid;
    close  = (state == FILL) &&
             ((accept && ((k == KW'(N_INPUTS - 1)) || bus.s_last || bus.flush)) ||
              (!accept && bus.flush && (k != '0)));
    state_nxt = state;
    case (state)
      FILL:    if (close) state_nxt = PRESENT;
      PRESENT: if (bus.frame_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    k_nxt       = k;
    data_nxt    = data_q;
    dir_nxt     = dir_q;
    words_nxt   = words_q;
    count_final = CW'(k) + CW'(accept);
    if (accept) begin
      data_nxt[int'(k)*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
      if (k == '0) dir_nxt = bus.direction_in;
      k_nxt = k + KW'(1);
    end
    if (close) begin
      k_nxt     = '0;
      words_nxt = count_final;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (i >= int'(count_final))
          data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{dir_nxt}};
      end
    end
    if (state == PRESENT && bus.frame_ready) k_nxt = '0;
  end

  always_comb begin
    bus.s_ready     = (state == FILL);
    bus.frame_valid = (state == PRESENT);
    bus.frame_data  = data_q;
    bus.frame_dir   = dir_q;
    bus.frame_words = words_q;
  end
endmodule

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader: expected frames are queued as
// words are driven and compared when the loader presents the frame.
module tb_sort_frame_loader;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sort_frame_loader_if #(.DATA_WIDTH(DW), .N_INPUTS(N), .CW(CW)) bus ();

  sort_frame_loader #(.DATA_WIDTH(DW), .N_INPUTS(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N*DW-1:0] data;
    logic            dir;
    logic [CW-1:0]   words;
  } frame_t;

  frame_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic frame_t model(input logic [DW-1:0] w[N], input int n, input logic dir);
    frame_t f;
    f.dir   = dir;
    f.words = CW'(n);
    for (int i = 0; i < N; i++)
      f.data[i*DW +: DW] = (i < n) ? w[i] : {DW{dir}};
    return f;
  endfunction

  task automatic idle_inputs();
    bus.s_valid      = 1'b0;
    bus.s_data       = '0;
    bus.s_last       = 1'b0;
    bus.flush        = 1'b0;
    bus.direction_in = 1'b0;
  endtask

  // direction_in is inverted after word 0 so the latch must hold the first value
  task automatic drive_frame(input logic [DW-1:0] w[N], input int n, input logic dir,
                             input logic close_last, input logic close_flush);
    sb.push_back(model(w, n, dir));
    for (int i = 0; i < n; i++) begin
      bus.s_valid      = 1'b1;
      bus.s_data       = w[i];
      bus.direction_in = (i == 0) ? dir : ~dir;
      bus.s_last       = close_last && (i == n - 1);
      bus.flush        = close_flush && (i == n - 1);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.frame_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.frame_valid, bus.frame_dir, bus.frame_words, bus.frame_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%0b dir=%0b words=%0d data=%h", bus.frame_valid,
               bus.frame_dir, bus.frame_words, bus.frame_data);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready got=%0b exp=1", bus.s_ready);
    end
  endtask

  task automatic test_full_frame();
    logic [DW-1:0] w[N];
    frame_t e;
    for (int i = 0; i < N; i++) w[i] = DW'(N - i);
    bus.frame_ready = 1'b1;
    drive_frame(w, N, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_latency valid=%0b ready=%0b exp 1/0", bus.frame_valid, bus.s_ready);
    end
    e = sb.pop_front();
    checks++;
    if ({bus.frame_data, bus.frame_dir, bus.frame_words} !== {e.data, e.dir, e.words}) begin
      errors++;
      $display("FAIL full_frame got=%h/%0b/%0d exp=%h/%0b/%0d", bus.frame_data, bus.frame_dir,
               bus.frame_words, e.data, e.dir, e.words);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_handoff ready=%0b valid=%0b exp 1/0", bus.s_ready, bus.frame_valid);
    end
  endtask

  task automatic test_short_frame();
    logic [DW-1:0] w[N];
    frame_t e;
    for (int i = 0; i < N; i++) w[i] = '0;
    w[0] = 5; w[1] = 9; w[2] = 2;
    for (int d = 1; d >= 0; d--) begin
      drive_frame(w, 3, d[0], 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.frame_valid !== 1'b1 ||
          {bus.frame_data, bus.frame_dir, bus.frame_words} !== {e.data, e.dir, e.words}) begin
        errors++;
        $display("FAIL short_dir%0d valid=%0b got=%h/%0b/%0d exp=%h/%0b/%0d", d, bus.frame_valid,
                 bus.frame_data, bus.frame_dir, bus.frame_words, e.data, e.dir, e.words);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[N];
    frame_t e;
    for (int i = 0; i < N; i++) w[i] = $urandom;
    bus.frame_ready = 1'b0;
    drive_frame(w, N, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = $urandom;
      bus.s_last  = 1'b1;
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.s_ready !== 1'b0 ||
          {bus.frame_data, bus.frame_dir, bus.frame_words} !== {e.data, e.dir, e.words}) begin
        errors++;
        $display("FAIL stall_cycle%0d valid=%0b ready=%0b got=%h/%0d exp=%h/%0d", c,
                 bus.frame_valid, bus.s_ready, bus.frame_data, bus.frame_words, e.data, e.words);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release ready=%0b valid=%0b exp 1/0", bus.s_ready, bus.frame_valid);
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] w[N];
    frame_t e;
    for (int i = 0; i < N; i++) w[i] = DW'(32'hA0 + i);
    drive_frame(w, 4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_early got=%0b exp=0", bus.frame_valid);
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.frame_valid !== 1'b1 ||
        {bus.frame_data, bus.frame_dir, bus.frame_words} !== {e.data, e.dir, e.words}) begin
      errors++;
      $display("FAIL flush_frame valid=%0b got=%h/%0d exp=%h/%0d", bus.frame_valid,
               bus.frame_data, bus.frame_words, e.data, e.words);
    end
    @(posedge clk); #1;
    bus.flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty valid=%0b ready=%0b exp 0/1", bus.frame_valid, bus.s_ready);
    end
    drive_frame(w, 2, 1'b0, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus.frame_valid !== 1'b1 ||
        {bus.frame_data, bus.frame_dir, bus.frame_words} !== {e.data, e.dir, e.words}) begin
      errors++;
      $display("FAIL last_and_flush valid=%0b got=%h/%0d exp=%h/%0d", bus.frame_valid,
               bus.frame_data, bus.frame_words, e.data, e.words);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fill();
    logic [DW-1:0] w[N];
    frame_t e;
    for (int i = 0; i < 5; i++) begin
      bus.s_valid      = 1'b1;
      bus.s_data       = DW'(32'hDEAD0000 + i);
      bus.direction_in = 1'b1;
      @(posedge clk); #1;
    end
    idle_inputs();
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({bus.frame_valid, bus.frame_dir, bus.frame_words, bus.frame_data} !== '0 ||
        bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset valid=%0b ready=%0b dir=%0b words=%0d data=%h", bus.frame_valid,
               bus.s_ready, bus.frame_dir, bus.frame_words, bus.frame_data);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) w[i] = DW'(32'h100 + i);
    drive_frame(w, N, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (bus.frame_valid !== 1'b1 ||
        {bus.frame_data, bus.frame_dir, bus.frame_words} !== {e.data, e.dir, e.words}) begin
      errors++;
      $display("FAIL post_reset_frame valid=%0b got=%h/%0d exp=%h/%0d", bus.frame_valid,
               bus.frame_data, bus.frame_words, e.data, e.words);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[N];
    logic dir;
    frame_t e;
    for (int n = 1; n <= N; n++) begin
      for (int i = 0; i < N; i++) w[i] = $urandom;
      dir = 1'($urandom_range(0, 1));
      drive_frame(w, n, dir, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.frame_valid !== 1'b1 ||
          {bus.frame_data, bus.frame_dir, bus.frame_words} !== {e.data, e.dir, e.words}) begin
        errors++;
        $display("FAIL b2b_n%0d valid=%0b got=%h/%0b/%0d exp=%h/%0b/%0d", n, bus.frame_valid,
                 bus.frame_data, bus.frame_dir, bus.frame_words, e.data, e.dir, e.words);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle_inputs();
    bus.frame_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_flush();
    test_reset_mid_fill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
